// File: rtl/pipeline_hold_ctrl.sv
// Central hazard/stall controller: sequences branch, load-use, trap, bus-wait and mul/div-wait
// stalls into per-stage write enables and hold codes, with a watchdog on the multi-cycle waits.
module pipeline_hold_ctrl #(
    parameter int unsigned TRAP_FLUSH_CYCLES = 2,
    parameter int unsigned WAIT_TIMEOUT      = 1024,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 branch_taken_i,
    input  logic                 load_use_i,
    input  logic                 trap_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ready_i,
    input  logic                 muldiv_start_i,
    input  logic                 muldiv_done_i,
    output logic                 pc_wen_o,
    output logic                 if_id_wen_o,
    output logic                 id_ex_wen_o,
    output logic                 ex_mem_wen_o,
    output logic                 mem_wb_wen_o,
    output logic [2:0]           if_id_hold_o,
    output logic [2:0]           id_ex_hold_o,
    output logic [2:0]           ex_mem_hold_o,
    output logic [2:0]           mem_wb_hold_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_MD_WAIT,
        ST_TRAP_FLUSH
    } state_e;

    typedef enum logic [2:0] {
        HOLD_NONE     = 3'b000,
        HOLD_BRANCH   = 3'b001,
        HOLD_LOAD_USE = 3'b010,
        HOLD_TRAP     = 3'b011,
        HOLD_WAIT     = 3'b100
    } hold_e;

    localparam int unsigned     WD_W       = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(WAIT_TIMEOUT - 1);
    localparam bit              WD_EN      = (WAIT_TIMEOUT != 0);
    localparam logic [3:0]      FLUSH_INIT = 4'(TRAP_FLUSH_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [3:0]             flush_q, flush_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [CNT_WIDTH-1:0]   stall_q, stall_d;
    logic                   trap_go;
    logic                   wd_expired;
    logic                   stall;

    assign wd_expired = WD_EN && (wd_q == WD_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        flush_d       = flush_q;
        wd_d          = wd_q;
        trap_go       = 1'b0;
        pc_wen_o      = 1'b1;
        if_id_wen_o   = 1'b1;
        id_ex_wen_o   = 1'b1;
        ex_mem_wen_o  = 1'b1;
        mem_wb_wen_o  = 1'b1;
        if_id_hold_o  = HOLD_NONE;
        id_ex_hold_o  = HOLD_NONE;
        ex_mem_hold_o = HOLD_NONE;
        mem_wb_hold_o = HOLD_NONE;
        timeout_o     = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (trap_i) begin
                    trap_go = 1'b1;
                end else if (mem_req_i && !mem_ready_i) begin
                    {pc_wen_o, if_id_wen_o, id_ex_wen_o, ex_mem_wen_o} = 4'b0000;
                    mem_wb_hold_o = HOLD_WAIT;
                    state_d       = ST_MEM_WAIT;
                    wd_d          = '0;
                end else if (muldiv_start_i) begin
                    {pc_wen_o, if_id_wen_o, id_ex_wen_o} = 3'b000;
                    ex_mem_hold_o = HOLD_WAIT;
                    if (!muldiv_done_i) begin
                        state_d = ST_MD_WAIT;
                        wd_d    = '0;
                    end
                end else if (branch_taken_i) begin
                    if_id_hold_o = HOLD_BRANCH;
                    id_ex_hold_o = HOLD_BRANCH;
                end else if (load_use_i) begin
                    pc_wen_o     = 1'b0;
                    if_id_wen_o  = 1'b0;
                    id_ex_hold_o = HOLD_LOAD_USE;
                end
            end
            // Completion wins over a watchdog expiry landing on the same cycle.
            ST_MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = ST_RUN;
                end else if (wd_expired) begin
                    trap_go   = 1'b1;
                    timeout_o = 1'b1;
                end else begin
                    {pc_wen_o, if_id_wen_o, id_ex_wen_o, ex_mem_wen_o} = 4'b0000;
                    mem_wb_hold_o = HOLD_WAIT;
                    wd_d          = wd_q + WD_W'(1);
                end
            end
            ST_MD_WAIT: begin
                if (muldiv_done_i) begin
                    state_d = ST_RUN;
                end else if (wd_expired) begin
                    trap_go   = 1'b1;
                    timeout_o = 1'b1;
                end else begin
                    {pc_wen_o, if_id_wen_o, id_ex_wen_o} = 3'b000;
                    ex_mem_hold_o = HOLD_WAIT;
                    wd_d          = wd_q + WD_W'(1);
                end
            end
            ST_TRAP_FLUSH: begin
                pc_wen_o      = 1'b0;
                if_id_hold_o  = HOLD_TRAP;
                id_ex_hold_o  = HOLD_TRAP;
                ex_mem_hold_o = HOLD_TRAP;
                flush_d       = flush_q - 4'd1;
                if (flush_q <= 4'd1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // A trap from RUN and a watchdog expiry share the same first flush cycle.
        if (trap_go) begin
            pc_wen_o      = 1'b1;
            if_id_hold_o  = HOLD_TRAP;
            id_ex_hold_o  = HOLD_TRAP;
            ex_mem_hold_o = HOLD_TRAP;
            if (TRAP_FLUSH_CYCLES > 1) begin
                state_d = ST_TRAP_FLUSH;
                flush_d = FLUSH_INIT;
            end else begin
                state_d = ST_RUN;
            end
        end

        stall = ~&{pc_wen_o, if_id_wen_o, id_ex_wen_o, ex_mem_wen_o, mem_wb_wen_o}
              | (|{if_id_hold_o, id_ex_hold_o, ex_mem_hold_o, mem_wb_hold_o});
        stall_d = (stall && (stall_q != '1)) ? stall_q + CNT_WIDTH'(1) : stall_q;

        if (!rst) begin
            {pc_wen_o, if_id_wen_o, id_ex_wen_o, ex_mem_wen_o, mem_wb_wen_o} = 5'b00000;
            if_id_hold_o  = HOLD_NONE;
            id_ex_hold_o  = HOLD_NONE;
            ex_mem_hold_o = HOLD_NONE;
            mem_wb_hold_o = HOLD_NONE;
            timeout_o     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            flush_q <= '0;
            wd_q    <= '0;
            stall_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge values.
            state_q <= state_d;
            flush_q <= flush_d;
            wd_q    <= wd_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Bench for pipeline_hold_ctrl: two instances (2- and 3-cycle trap flush, watchdog of 8) share
// directed and random stimulus and are compared every cycle against a cycle-level reference model.
module tb_pipeline_hold_ctrl;

    localparam int WT = 8;
    localparam int M_RUN = 0, M_MEM = 1, M_MD = 2, M_FLUSH = 3;

    typedef struct packed {
        logic trap, mem_req, mem_ready, md_start, md_done, branch, load_use;
    } stim_t;

    typedef struct packed {
        logic       pc, ifid, idex, exmem, memwb;
        logic [2:0] h_ifid, h_idex, h_exmem, h_memwb;
        logic       to;
    } exp_t;

    typedef struct {
        int     mode;
        int     waited;
        int     flush_left;
        longint stalls;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic branch_taken_i = 1'b0, load_use_i = 1'b0, trap_i = 1'b0;
    logic mem_req_i = 1'b0, mem_ready_i = 1'b0, muldiv_start_i = 1'b0, muldiv_done_i = 1'b0;

    logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_to;
    logic [2:0]  a_h_ifid, a_h_idex, a_h_exmem, a_h_memwb;
    logic [31:0] a_cnt;
    logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_to;
    logic [2:0]  b_h_ifid, b_h_idex, b_h_exmem, b_h_memwb;
    logic [3:0]  b_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    mdl_t m_a, m_b;

    always #5 clk = ~clk;

    pipeline_hold_ctrl #(.TRAP_FLUSH_CYCLES(2), .WAIT_TIMEOUT(WT), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst),
        .branch_taken_i(branch_taken_i), .load_use_i(load_use_i), .trap_i(trap_i),
        .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .muldiv_start_i(muldiv_start_i), .muldiv_done_i(muldiv_done_i),
        .pc_wen_o(a_pc), .if_id_wen_o(a_ifid), .id_ex_wen_o(a_idex),
        .ex_mem_wen_o(a_exmem), .mem_wb_wen_o(a_memwb),
        .if_id_hold_o(a_h_ifid), .id_ex_hold_o(a_h_idex),
        .ex_mem_hold_o(a_h_exmem), .mem_wb_hold_o(a_h_memwb),
        .timeout_o(a_to), .stall_cnt_o(a_cnt)
    );

    pipeline_hold_ctrl #(.TRAP_FLUSH_CYCLES(3), .WAIT_TIMEOUT(WT), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .branch_taken_i(branch_taken_i), .load_use_i(load_use_i), .trap_i(trap_i),
        .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .muldiv_start_i(muldiv_start_i), .muldiv_done_i(muldiv_done_i),
        .pc_wen_o(b_pc), .if_id_wen_o(b_ifid), .id_ex_wen_o(b_idex),
        .ex_mem_wen_o(b_exmem), .mem_wb_wen_o(b_memwb),
        .if_id_hold_o(b_h_ifid), .id_ex_hold_o(b_h_idex),
        .ex_mem_hold_o(b_h_exmem), .mem_wb_hold_o(b_h_memwb),
        .timeout_o(b_to), .stall_cnt_o(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic stim_t mk(input logic trap, mreq, mrdy, mds, mdd, br, lu);
        return '{trap, mreq, mrdy, mds, mdd, br, lu};
    endfunction

    function automatic exp_t obs_a();
        return '{a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_h_ifid, a_h_idex, a_h_exmem, a_h_memwb, a_to};
    endfunction

    function automatic exp_t obs_b();
        return '{b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_h_ifid, b_h_idex, b_h_exmem, b_h_memwb, b_to};
    endfunction

    function automatic exp_t idle_out();
        exp_t e;
        e = '0;
        {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b11111;
        return e;
    endfunction

    function automatic void model_reset(output mdl_t m);
        m.mode = M_RUN; m.waited = 0; m.flush_left = 0; m.stalls = 0;
    endfunction

    // One clock of the controller described by its rules: expected outputs now, model state next.
    function automatic void model_step(input mdl_t m, input int tfc, input longint cmax,
                                       input stim_t s, output exp_t e, output mdl_t n);
        logic trap_now = 1'b0;
        n = m;
        e = idle_out();
        case (m.mode)
            M_RUN: begin
                if (s.trap) trap_now = 1'b1;
                else if (s.mem_req && !s.mem_ready) begin
                    {e.pc, e.ifid, e.idex, e.exmem} = 4'b0; e.h_memwb = 3'd4;
                    n.mode = M_MEM; n.waited = 0;
                end else if (s.md_start) begin
                    {e.pc, e.ifid, e.idex} = 3'b0; e.h_exmem = 3'd4;
                    if (!s.md_done) begin n.mode = M_MD; n.waited = 0; end
                end else if (s.branch) begin
                    e.h_ifid = 3'd1; e.h_idex = 3'd1;
                end else if (s.load_use) begin
                    e.pc = 1'b0; e.ifid = 1'b0; e.h_idex = 3'd2;
                end
            end
            M_MEM: begin
                if (s.mem_ready) n.mode = M_RUN;
                else if (m.waited + 1 == WT) begin trap_now = 1'b1; e.to = 1'b1; end
                else begin
                    {e.pc, e.ifid, e.idex, e.exmem} = 4'b0; e.h_memwb = 3'd4;
                    n.waited = m.waited + 1;
                end
            end
            M_MD: begin
                if (s.md_done) n.mode = M_RUN;
                else if (m.waited + 1 == WT) begin trap_now = 1'b1; e.to = 1'b1; end
                else begin
                    {e.pc, e.ifid, e.idex} = 3'b0; e.h_exmem = 3'd4;
                    n.waited = m.waited + 1;
                end
            end
            default: begin
                e.pc = 1'b0; e.h_ifid = 3'd3; e.h_idex = 3'd3; e.h_exmem = 3'd3;
                n.flush_left = m.flush_left - 1;
                if (n.flush_left == 0) n.mode = M_RUN;
            end
        endcase
        if (trap_now) begin
            e.pc = 1'b1; e.h_ifid = 3'd3; e.h_idex = 3'd3; e.h_exmem = 3'd3;
            n.flush_left = tfc - 1;
            n.mode = (tfc > 1) ? M_FLUSH : M_RUN;
        end
        if ((!(e.pc && e.ifid && e.idex && e.exmem && e.memwb) ||
             (e.h_ifid | e.h_idex | e.h_exmem | e.h_memwb) != 3'd0) && m.stalls < cmax)
            n.stalls = m.stalls + 1;
    endfunction

    task automatic cycle(input stim_t s);
        exp_t ea, eb;
        mdl_t na, nb;
        @(negedge clk);
        trap_i = s.trap; mem_req_i = s.mem_req; mem_ready_i = s.mem_ready;
        muldiv_start_i = s.md_start; muldiv_done_i = s.md_done;
        branch_taken_i = s.branch; load_use_i = s.load_use;
        #1;
        model_step(m_a, 2, 64'hFFFF_FFFF, s, ea, na);
        model_step(m_b, 3, 15, s, eb, nb);
        check("a_out", 64'(obs_a()), 64'(ea));
        check("a_cnt", 64'(a_cnt), 64'(m_a.stalls));
        check("b_out", 64'(obs_b()), 64'(eb));
        check("b_cnt", 64'(b_cnt), 64'(m_b.stalls));
        m_a = na;
        m_b = nb;
    endtask

    // Reset asserted between clock edges must act at once and hold across an edge.
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_a_out", 64'(obs_a()), 64'd0);
        check("rst_a_cnt", 64'(a_cnt), 64'd0);
        check("rst_b_out", 64'(obs_b()), 64'd0);
        check("rst_b_cnt", 64'(b_cnt), 64'd0);
        {trap_i, mem_req_i, mem_ready_i, muldiv_start_i, muldiv_done_i, branch_taken_i, load_use_i} = '0;
        model_reset(m_a);
        model_reset(m_b);
        @(negedge clk);
        #1;
        check("rst_hold_a", 64'(obs_a()), 64'd0);
        check("rst_hold_b_cnt", 64'(b_cnt), 64'd0);
        rst = 1'b1;
    endtask

    function automatic stim_t rand_stim();
        return mk($urandom_range(99) < 6,  $urandom_range(99) < 25, $urandom_range(99) < 40,
                  $urandom_range(99) < 12, $urandom_range(99) < 25, $urandom_range(99) < 20,
                  $urandom_range(99) < 20);
    endfunction

    initial begin
        stim_t idle;
        idle = '0;
        model_reset(m_a);
        model_reset(m_b);

        @(negedge clk);
        #1;
        check("init_rst_out", 64'(obs_a()), 64'd0);
        check("init_rst_cnt", 64'(a_cnt), 64'd0);
        rst = 1'b1;

        cycle(idle);
        check("run_default", 64'(obs_a()), 64'(idle_out()));

        cycle(mk(0, 0, 0, 0, 0, 1, 0));
        check("branch_hold", {a_h_ifid, a_h_idex, a_pc}, {3'd1, 3'd1, 1'b1});
        cycle(idle);
        check("branch_after", 64'(obs_a()), 64'(idle_out()));
        check("branch_cnt", 64'(a_cnt), 64'd1);

        cycle(mk(0, 0, 0, 0, 0, 1, 1));
        check("br_beats_lu", {a_h_ifid, a_h_idex}, {3'd1, 3'd1});
        cycle(mk(0, 0, 0, 0, 0, 0, 1));
        check("load_use", {a_pc, a_ifid, a_h_idex}, {1'b0, 1'b0, 3'd2});
        cycle(idle);

        cycle(mk(0, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++) begin
            cycle(mk(i == 2, 1, 0, 0, 0, 1, 0));
            check("mem_wait", {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_h_ifid, a_h_memwb},
                  {4'b0000, 1'b1, 3'd0, 3'd4});
        end
        cycle(mk(0, 1, 1, 0, 0, 0, 0));
        check("mem_ready", 64'(obs_a()), 64'(idle_out()));
        check("mem_cnt", 64'(a_cnt), 64'd8);
        cycle(idle);

        cycle(mk(0, 0, 0, 1, 0, 0, 0));
        for (int i = 1; i <= WT; i++) begin
            cycle(idle);
            check("md_timeout", {a_to, b_to}, (i == WT) ? 2'b11 : 2'b00);
        end
        check("to_trap_out", {a_h_ifid, a_h_idex, a_h_exmem, a_pc}, {3'd3, 3'd3, 3'd3, 1'b1});
        cycle(idle);
        check("to_flush_a", {a_h_ifid, a_pc, a_to}, {3'd3, 1'b0, 1'b0});
        cycle(idle);
        check("to_done_a", 64'(a_h_ifid), 64'd0);
        cycle(idle);

        cycle(mk(1, 0, 0, 0, 0, 0, 0));
        check("trap_b_1", {b_h_ifid, b_h_idex, b_h_exmem, b_pc}, {3'd3, 3'd3, 3'd3, 1'b1});
        cycle(mk(1, 0, 0, 0, 0, 0, 0));
        check("trap_b_2", {b_h_ifid, b_h_idex, b_h_exmem, b_pc}, {3'd3, 3'd3, 3'd3, 1'b0});
        cycle(idle);
        check("trap_b_3", {b_h_ifid, b_h_idex, b_h_exmem, b_pc}, {3'd3, 3'd3, 3'd3, 1'b0});
        cycle(idle);
        check("trap_b_end", 64'(obs_b()), 64'(idle_out()));

        cycle(mk(0, 1, 0, 0, 0, 0, 0));
        cycle(mk(0, 1, 0, 0, 0, 0, 0));
        async_reset();
        cycle(idle);
        check("post_rst_out", 64'(obs_a()), 64'(idle_out()));
        check("post_rst_cnt", 64'(a_cnt), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) async_reset();
            else cycle(rand_stim());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
